cu_sequencer: RTL and testbench

CU_SEQUENCER -- requirements
Module: cu_sequencer

---
 rtl/cu_pkg.sv | 109 ++++++++++
 rtl/cu_ctrl_decode.sv | 123 ++++++++++++
 rtl/cu_sequencer.sv | 116 +++++++++++
 tb/tb_cu_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared constants for the control-unit sequencer.
// Holds opcodes, ALU codes, FSM states, control-bit indices and opcode
// classification helpers. The MPY opcode is legal only when CU_MPY_EN
// is defined; otherwise 08 decodes as undefined.
package cu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_F0,
      S_F1,
      S_F2,
      S_F3,
      S_DEC,
      S_EX,
      S_HALT
   } state_t;

   // Execute-phase shape of an opcode.
   typedef enum logic [2:0] {
      K_NONE,
      K_MEM_ALU,
      K_LOAD,
      K_STORE,
      K_JUMP,
      K_REG_ALU
   } op_kind_t;

   localparam logic [7:0] OP_STORE = 8'h01;
   localparam logic [7:0] OP_LOAD  = 8'h02;
   localparam logic [7:0] OP_ADD   = 8'h03;
   localparam logic [7:0] OP_SUB   = 8'h04;
   localparam logic [7:0] OP_JGEZ  = 8'h05;
   localparam logic [7:0] OP_JMP   = 8'h06;
   localparam logic [7:0] OP_HALT  = 8'h07;
   localparam logic [7:0] OP_MPY   = 8'h08;
   localparam logic [7:0] OP_AND   = 8'h0A;
   localparam logic [7:0] OP_OR    = 8'h0B;
   localparam logic [7:0] OP_NOT   = 8'h0C;
   localparam logic [7:0] OP_SHR   = 8'h0D;
   localparam logic [7:0] OP_SHL   = 8'h0E;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOT = 3'b100;
   localparam logic [2:0] ALU_SHR = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b110;
   localparam logic [2:0] ALU_MPY = 3'b111;

   // Control word bit positions.
   localparam int C0         = 0;
   localparam int C2         = 2;
   localparam int C3         = 3;
   localparam int C4         = 4;
   localparam int C5         = 5;
   localparam int C6         = 6;
   localparam int C7         = 7;
   localparam int C8         = 8;
   localparam int C9         = 9;
   localparam int C11        = 11;
   localparam int C12        = 12;
   localparam int C13        = 13;
   localparam int C14        = 14;
   localparam int C15        = 15;
   localparam int ALU_OP_LSB = 16;
   localparam int ALU_EN     = 19;
   localparam int MAR_INC    = 22;
   localparam int HALT_BIT   = 23;

   // Flag vector is {MF,NF,OF,CF,ZF}.
   localparam int FLAG_NF = 3;

   function automatic op_kind_t op_kind(input logic [7:0] op);
      op_kind_t k;
      k = K_NONE;
      case (op)
         OP_ADD, OP_SUB,
         OP_AND, OP_OR:    k = K_MEM_ALU;
`ifdef CU_MPY_EN
         OP_MPY:           k = K_MEM_ALU;
`endif
         OP_LOAD:          k = K_LOAD;
         OP_STORE:         k = K_STORE;
         OP_JMP, OP_JGEZ:  k = K_JUMP;
         OP_NOT, OP_SHR,
         OP_SHL:           k = K_REG_ALU;
         default:          k = K_NONE;
      endcase
      return k;
   endfunction

   function automatic logic [2:0] alu_code(input logic [7:0] op);
      logic [2:0] c;
      c = ALU_ADD;
      case (op)
         OP_SUB:  c = ALU_SUB;
         OP_AND:  c = ALU_AND;
         OP_OR:   c = ALU_OR;
         OP_NOT:  c = ALU_NOT;
         OP_SHR:  c = ALU_SHR;
         OP_SHL:  c = ALU_SHL;
         OP_MPY:  c = ALU_MPY;
         default: c = ALU_ADD;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cu_ctrl_decode.sv
// cu_ctrl_decode: pure Moore decode of state/step/latched opcode into the
// 24-bit control word, memory write strobe and instruction-done pulse.
// Ports: state, step, opcode (latched), nf (latched NF) -> ctrl, mem_wr, done.
// Macro CU_MPY_EN (via cu_pkg::op_kind) enables the MPY execute sequence.
module cu_ctrl_decode
   import cu_pkg::*;
(
   input  logic [2:0]  state,
   input  logic [2:0]  step,
   input  logic [7:0]  opcode,
   input  logic        nf,
   output logic [23:0] ctrl,
   output logic        mem_wr,
   output logic        done
);

   state_t   st;
   op_kind_t kind;

   assign st = state_t'(state);

   always_comb begin
      ctrl   = '0;
      mem_wr = 1'b0;
      done   = 1'b0;
      kind   = op_kind(opcode);
      case (st)
         S_F0:  ctrl[C2] = 1'b1;
         S_F1: begin
            ctrl[C0] = 1'b1;
            ctrl[C5] = 1'b1;
         end
         S_F2:  ctrl[C4] = 1'b1;
         S_F3:  ctrl[C14] = 1'b1;
         // Not-taken JGEZ retires straight out of DEC.
         S_DEC: done = (opcode == OP_JGEZ) && nf;
         S_EX: begin
            case (kind)
               K_MEM_ALU: begin
                  case (step)
                     3'd0: ctrl[C15] = 1'b1;
                     3'd1: ctrl[C8] = 1'b1;
                     3'd2: begin
                        ctrl[C0] = 1'b1;
                        ctrl[C5] = 1'b1;
                     end
                     3'd3: begin
                        ctrl[C6]     = 1'b1;
                        ctrl[C7]     = 1'b1;
                        ctrl[ALU_EN] = 1'b1;
                        ctrl[ALU_OP_LSB +: 3] = alu_code(opcode);
                     end
                     3'd4: begin
                        ctrl[C9] = 1'b1;
                        done     = 1'b1;
                     end
                     default: ;
                  endcase
               end
               K_LOAD: begin
                  case (step)
                     3'd0: ctrl[C15] = 1'b1;
                     3'd1: ctrl[C8] = 1'b1;
                     3'd2: begin
                        ctrl[C0] = 1'b1;
                        ctrl[C5] = 1'b1;
                     end
                     3'd3: begin
                        ctrl[C11] = 1'b1;
                        done      = 1'b1;
                     end
                     default: ;
                  endcase
               end
               K_STORE: begin
                  case (step)
                     3'd0: ctrl[C15] = 1'b1;
                     3'd1: ctrl[C8] = 1'b1;
                     3'd2: ctrl[C12] = 1'b1;
                     3'd3: begin
                        ctrl[C0]  = 1'b1;
                        ctrl[C13] = 1'b1;
                        mem_wr    = 1'b1;
                        done      = 1'b1;
                     end
                     default: ;
                  endcase
               end
               K_JUMP: begin
                  case (step)
                     3'd0: ctrl[C15] = 1'b1;
                     3'd1: begin
                        ctrl[C3] = 1'b1;
                        done     = 1'b1;
                     end
                     default: ;
                  endcase
               end
               K_REG_ALU: begin
                  case (step)
                     3'd0: begin
                        ctrl[C7]     = 1'b1;
                        ctrl[ALU_EN] = 1'b1;
                        ctrl[ALU_OP_LSB +: 3] = alu_code(opcode);
                     end
                     3'd1: begin
                        ctrl[C9] = 1'b1;
                        done     = 1'b1;
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
         S_HALT: ctrl[HALT_BIT] = 1'b1;
         default: ;
      endcase
      // Reserved for block transfer; never driven.
      ctrl[MAR_INC] = 1'b0;
   end

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: Moore control-unit FSM (IDLE, F0-F3, DEC, EX steps, HALT).
// Ports: i_clk, i_rst (async, active high), i_run, i_ir_opcode, i_flags,
// i_mem_ready -> o_ctrl[23:0], o_mem_wr, o_instr_done, o_illegal (sticky).
// Macro CU_MPY_EN: when defined, opcode 08 executes as MPY; else undefined.
module cu_sequencer
   import cu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_run,
   input  logic [7:0]  i_ir_opcode,
   input  logic [4:0]  i_flags,
   input  logic        i_mem_ready,
   output logic [23:0] o_ctrl,
   output logic        o_mem_wr,
   output logic        o_instr_done,
   output logic        o_illegal
);

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  step_q;
   logic [2:0]  step_d;
   logic [7:0]  op_q;
   logic        nf_q;
   logic        illegal_q;
   logic        illegal_d;
   logic [23:0] ctrl;
   logic        done;
   logic        stall;
   logic        flags_unused;

   assign flags_unused = ^{i_flags[4], i_flags[2:0]};

   // Memory steps hold until the access completes.
   assign stall = ctrl[C0] & (ctrl[C5] | ctrl[C13]) & ~i_mem_ready;

   // The IR is already loaded while F3 runs, so opcode and NF are
   // registered on the F3->DEC edge. DEC then decodes from registers,
   // keeping every output free of an input path.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         step_q    <= 3'd0;
         op_q      <= 8'h00;
         nf_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         illegal_q <= illegal_d;
         if (state_q == S_F3) begin
            op_q <= i_ir_opcode;
            nf_q <= i_flags[FLAG_NF];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      illegal_d = illegal_q;
      if (!stall) begin
         case (state_q)
            S_IDLE: begin
               if (i_run) begin
                  state_d = S_F0;
                  step_d  = 3'd0;
               end
            end
            S_F0: state_d = S_F1;
            S_F1: state_d = S_F2;
            S_F2: state_d = S_F3;
            S_F3: state_d = S_DEC;
            S_DEC: begin
               if (op_q == OP_HALT) begin
                  state_d = S_HALT;
               end else if (op_kind(op_q) == K_NONE) begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end else if (done) begin
                  state_d = S_F0;
               end else begin
                  state_d = S_EX;
                  step_d  = 3'd0;
               end
            end
            S_EX: begin
               if (done) begin
                  state_d = S_F0;
                  step_d  = 3'd0;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   cu_ctrl_decode u_decode (
      .state  (state_q),
      .step   (step_q),
      .opcode (op_q),
      .nf     (nf_q),
      .ctrl   (ctrl),
      .mem_wr (o_mem_wr),
      .done   (done)
   );

   assign o_ctrl       = ctrl;
   assign o_instr_done = done;
   assign o_illegal    = illegal_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: table-driven instruction vectors plus hand sequences
// for halt, illegal opcodes and asynchronous reset, scoreboard checked.
module tb_cu_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_run;
   logic [7:0]  i_ir_opcode;
   logic [4:0]  i_flags;
   logic        i_mem_ready;
   logic [23:0] o_ctrl;
   logic        o_mem_wr;
   logic        o_instr_done;
   logic        o_illegal;

   cu_sequencer dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_run        (i_run),
      .i_ir_opcode  (i_ir_opcode),
      .i_flags      (i_flags),
      .i_mem_ready  (i_mem_ready),
      .o_ctrl       (o_ctrl),
      .o_mem_wr     (o_mem_wr),
      .o_instr_done (o_instr_done),
      .o_illegal    (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0]       op;
      logic [4:0]       fl;
      int               f1_wait;
      int               wait_at;
      int               wait_n;
      int               wr_step;
      int               n;
      logic [4:0][23:0] ex;
   } vec_t;

   vec_t        tab[$];
   logic [26:0] sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic add(input logic [7:0] op, input logic [4:0] fl,
                      input int f1w, input int wa, input int wn,
                      input int wr, input int n,
                      input logic [23:0] w0, input logic [23:0] w1,
                      input logic [23:0] w2, input logic [23:0] w3,
                      input logic [23:0] w4);
      vec_t v;
      v.op = op;
      v.fl = fl;
      v.f1_wait = f1w;
      v.wait_at = wa;
      v.wait_n = wn;
      v.wr_step = wr;
      v.n = n;
      v.ex[0] = w0;
      v.ex[1] = w1;
      v.ex[2] = w2;
      v.ex[3] = w3;
      v.ex[4] = w4;
      tab.push_back(v);
   endtask

   task automatic check(input string tag);
      logic [26:0] e;
      logic [26:0] a;
      a = {o_ctrl, o_mem_wr, o_instr_done, o_illegal};
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got ctrl=%h wr=%b done=%b ill=%b, want ctrl=%h wr=%b done=%b ill=%b",
                  tag, a[26:3], a[2], a[1], a[0], e[26:3], e[2], e[1], e[0]);
      end
   endtask

   // Expect outputs for the current cycle, then advance one clock.
   task automatic cyc(input logic [23:0] c, input logic w, input logic d,
                      input logic il, input logic rdy, input string tag);
      i_mem_ready = rdy;
      sb.push_back({c, w, d, il});
      check(tag);
      @(negedge i_clk);
   endtask

   task automatic fetch(input logic [7:0] op, input string tag);
      i_ir_opcode = op;
      cyc(24'h000004, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_f0"});
      cyc(24'h000021, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_f1"});
      cyc(24'h000010, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_f2"});
      cyc(24'h004000, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_f3"});
      cyc(24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_dec"});
   endtask

   task automatic rst_pulse(input string tag);
      i_rst = 1'b1;
      #1;
      sb.push_back(27'h0);
      check(tag);
      @(negedge i_clk);
      i_rst = 1'b0;
      i_run = 1'b0;
   endtask

   task automatic run_start(input string tag);
      i_run = 1'b1;
      cyc(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
      i_run = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic last;
      logic wr;
      string t;

      add(8'h02, 5'b00000, 0, -1, 0, -1, 4,
          24'h8000, 24'h100, 24'h21, 24'h800, 24'h0);
      add(8'h03, 5'b00000, 0, 2, 3, -1, 5,
          24'h8000, 24'h100, 24'h21, 24'h800C0, 24'h200);
      add(8'h04, 5'b00000, 2, -1, 0, -1, 5,
          24'h8000, 24'h100, 24'h21, 24'h900C0, 24'h200);
      add(8'h0A, 5'b00001, 0, -1, 0, -1, 5,
          24'h8000, 24'h100, 24'h21, 24'hA00C0, 24'h200);
      add(8'h0B, 5'b00000, 0, -1, 0, -1, 5,
          24'h8000, 24'h100, 24'h21, 24'hB00C0, 24'h200);
      add(8'h01, 5'b00000, 0, 3, 1, 3, 4,
          24'h8000, 24'h100, 24'h1000, 24'h2001, 24'h0);
      add(8'h05, 5'b01000, 0, -1, 0, -1, 0,
          24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      add(8'h05, 5'b10111, 0, -1, 0, -1, 2,
          24'h8000, 24'h8, 24'h0, 24'h0, 24'h0);
      add(8'h06, 5'b01000, 0, -1, 0, -1, 2,
          24'h8000, 24'h8, 24'h0, 24'h0, 24'h0);
      add(8'h0C, 5'b00000, 0, -1, 0, -1, 2,
          24'hC0080, 24'h200, 24'h0, 24'h0, 24'h0);
      add(8'h0D, 5'b00000, 0, -1, 0, -1, 2,
          24'hD0080, 24'h200, 24'h0, 24'h0, 24'h0);
      add(8'h0E, 5'b00000, 0, -1, 0, -1, 2,
          24'hE0080, 24'h200, 24'h0, 24'h0, 24'h0);
      add(8'h02, 5'b00000, 0, 2, 1, -1, 4,
          24'h8000, 24'h100, 24'h21, 24'h800, 24'h0);
`ifdef CU_MPY_EN
      add(8'h08, 5'b00000, 0, -1, 0, -1, 5,
          24'h8000, 24'h100, 24'h21, 24'hF00C0, 24'h200);
`endif

      i_rst = 1'b1;
      i_run = 1'b0;
      i_ir_opcode = 8'h00;
      i_flags = 5'b0;
      i_mem_ready = 1'b1;
      @(negedge i_clk);
      sb.push_back(27'h0);
      check("reset");
      i_rst = 1'b0;
      cyc(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "idle0");
      cyc(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "idle1");
      run_start("idle_run");

      foreach (tab[v]) begin
         i_ir_opcode = tab[v].op;
         i_flags = tab[v].fl;
         t = $sformatf("v%0d", v);
         cyc(24'h4, 1'b0, 1'b0, 1'b0, 1'b1, {t, "_f0"});
         for (int i = 0; i < tab[v].f1_wait; i++)
            cyc(24'h21, 1'b0, 1'b0, 1'b0, 1'b0, {t, "_f1w"});
         cyc(24'h21, 1'b0, 1'b0, 1'b0, 1'b1, {t, "_f1"});
         cyc(24'h10, 1'b0, 1'b0, 1'b0, 1'b1, {t, "_f2"});
         cyc(24'h4000, 1'b0, 1'b0, 1'b0, 1'b1, {t, "_f3"});
         cyc(24'h0, 1'b0, tab[v].n == 0, 1'b0, 1'b1, {t, "_dec"});
         for (int s = 0; s < tab[v].n; s++) begin
            last = (s == tab[v].n - 1);
            wr = (s == tab[v].wr_step);
            if (s == tab[v].wait_at)
               for (int i = 0; i < tab[v].wait_n; i++)
                  cyc(tab[v].ex[s], wr, last, 1'b0, 1'b0,
                      $sformatf("%s_ex%0dw", t, s));
            cyc(tab[v].ex[s], wr, last, 1'b0, 1'b1,
                $sformatf("%s_ex%0d", t, s));
         end
      end

      // HALT opcode: halts without flagging illegal.
      fetch(8'h07, "halt");
      for (int i = 0; i < 3; i++)
         cyc(24'h800000, 1'b0, 1'b0, 1'b0, 1'b1, "halt_hold");
      rst_pulse("rst_halt");
      cyc(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_after_halt");

      // Undefined opcode: halts, sticky illegal, cleared only by reset.
      run_start("run_ff");
      fetch(8'hFF, "ill");
      for (int i = 0; i < 20; i++)
         cyc(24'h800000, 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("ill_hold%0d", i));
      rst_pulse("rst_ill");
      cyc(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_after_ill");

`ifndef CU_MPY_EN
      run_start("run_mpy");
      fetch(8'h08, "mpy_off");
      cyc(24'h800000, 1'b0, 1'b0, 1'b1, 1'b1, "mpy_off_halt0");
      cyc(24'h800000, 1'b0, 1'b0, 1'b1, 1'b1, "mpy_off_halt1");
      rst_pulse("rst_mpy");
`endif

      // Reset in the middle of a stalled STORE write.
      run_start("run_st");
      fetch(8'h01, "st");
      cyc(24'h8000, 1'b0, 1'b0, 1'b0, 1'b1, "st_ex0");
      cyc(24'h100, 1'b0, 1'b0, 1'b0, 1'b1, "st_ex1");
      cyc(24'h1000, 1'b0, 1'b0, 1'b0, 1'b1, "st_ex2");
      cyc(24'h2001, 1'b1, 1'b1, 1'b0, 1'b0, "st_ex3_a");
      i_mem_ready = 1'b0;
      sb.push_back({24'h2001, 1'b1, 1'b1, 1'b0});
      check("st_ex3_b");
      #2;
      i_rst = 1'b1;
      #1;
      sb.push_back(27'h0);
      check("st_rst_async");
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 3; i++)
         cyc(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "st_idle");
      run_start("run_ld");
      i_flags = 5'b0;
      fetch(8'h02, "ld2");
      cyc(24'h8000, 1'b0, 1'b0, 1'b0, 1'b1, "ld2_ex0");
      cyc(24'h100, 1'b0, 1'b0, 1'b0, 1'b1, "ld2_ex1");
      cyc(24'h21, 1'b0, 1'b0, 1'b0, 1'b1, "ld2_ex2");
      cyc(24'h800, 1'b0, 1'b1, 1'b0, 1'b1, "ld2_ex3");
      cyc(24'h4, 1'b0, 1'b0, 1'b0, 1'b1, "ld2_next_f0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
